// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux select sequencer.
// Holds the FSM state enum, widths and slot counts.
package mux_seq_pkg;

  localparam int SEL_W  = 2;
  localparam int DATA_W = 4;

  // Data slots per word, and total slots including parity.
  localparam int N_DATA_SLOTS = 4;
`ifdef MUX_SEL_SEQ_PARITY_EN
  localparam int N_SLOTS = N_DATA_SLOTS + 1;
`else
  localparam int N_SLOTS = N_DATA_SLOTS;
`endif

  localparam logic [SEL_W-1:0] SEL_LO = '0;
  localparam logic [SEL_W-1:0] SEL_HI = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef MUX_SEL_SEQ_PARITY_EN
    ST_SHIFT = 2'd1,
    ST_PARITY = 2'd2
`else
    ST_SHIFT = 2'd1
`endif
  } state_t;

  // Select value of the first slot of a word.
  function automatic logic [SEL_W-1:0] sel_first(
    input bit lsb_first
  );
    return lsb_first ? SEL_LO : SEL_HI;
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_sel_counter.sv
// 2-bit up/down select counter with load, enable and terminal flag.
// Ports: clk, rst_n (sync, active-low), i_load, i_load_val, i_en,
//        o_cnt (current select), o_term (at last select of direction).
module sel_counter
  import mux_seq_pkg::*;
#(
  parameter bit UP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [SEL_W-1:0] i_load_val,
  input  logic             i_en,
  output logic [SEL_W-1:0] o_cnt,
  output logic             o_term
);

  logic [SEL_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      if (UP) r_cnt <= r_cnt + 2'd1;
      else    r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == (UP ? SEL_HI : SEL_LO));

endmodule

// File: rtl/mux_sel_sequencer.sv
// Serialises 4-bit words into a 4:1 mux select sequence, one slot/cycle.
// Ports: clk, rst_n (sync, active-low), in_valid/in_data/in_ready
//   (upstream handshake), d/s (downstream mux data and select),
//   y (local d[s] or parity), y_valid, last (final slot of word).
// Parameter LSB_FIRST: 1 = select 0..3, 0 = select 3..0.
// Optional macro MUX_SEL_SEQ_PARITY_EN adds an even-parity slot.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] d,
  output logic [SEL_W-1:0]  s,
  output logic              y,
  output logic              y_valid,
  output logic              last
);

  localparam bit LSB = (LSB_FIRST != 0);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_d;
  logic [SEL_W-1:0]  w_sel;
  logic              w_term;
  logic              w_last;
  logic              w_accept;
  logic              w_cnt_en;
  logic              w_y;
  logic              w_y_valid;

  sel_counter #(
    .UP (LSB)
  ) u_sel (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (sel_first(LSB)),
    .i_en       (w_cnt_en),
    .o_cnt      (w_sel),
    .o_term     (w_term)
  );

`ifdef MUX_SEL_SEQ_PARITY_EN
  assign w_last = (r_state == ST_PARITY);
`else
  assign w_last = (r_state == ST_SHIFT) && w_term;
`endif

  // Held low in reset so nothing is offered as accepted there.
  assign in_ready =
    rst_n && ((r_state == ST_IDLE) || w_last);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_d     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_d <= in_data;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_y       = 1'b0;
    w_y_valid = 1'b0;
    w_cnt_en  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_y_valid = 1'b1;
        w_y       = r_d[w_sel];
        if (!w_term) begin
          w_cnt_en = 1'b1;
        end else begin
`ifdef MUX_SEL_SEQ_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = w_accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef MUX_SEL_SEQ_PARITY_EN
      ST_PARITY: begin
        w_y_valid = 1'b1;
        w_y       = ^r_d;
        w_next    = w_accept ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign d       = r_d;
  assign s       = w_sel;
  assign y       = w_y;
  assign y_valid = w_y_valid;
  assign last    = w_last;

endmodule

// File: doc/mux_sel_sequencer.md
MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1: 1 = select order 0,1,2,3; 0 = select order 3,2,1,0.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-005 The block SHALL have port in_data, input, 4 bits: word to serialise.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-007 The block SHALL have port d, output, 4 bits: held word, driven to the downstream 4:1 mux data input.
REQ-008 The block SHALL have port s, output, 2 bits: select, driven to the downstream 4:1 mux select input.
REQ-009 The block SHALL have port y, output, 1 bit: local copy of the selected bit, d[s], or parity in the parity slot.
REQ-010 The block SHALL have port y_valid, output, 1 bit: y, d and s are meaningful this cycle.
REQ-011 The block SHALL have port last, output, 1 bit: final slot of the current word.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY exists only with the macro of REQ-025.
REQ-013 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data is captured into d.
REQ-014 in_ready SHALL be 1 in IDLE and in the final slot (last=1); it SHALL be 0 otherwise.
REQ-015 An accept SHALL move the FSM to SHIFT with s at its first value, 0 or 3 per LSB_FIRST, on the next cycle; latency is 1 cycle from accept to the first y_valid.
REQ-016 In SHIFT, s SHALL step once per cycle in order; y SHALL equal d[s] combinationally; y_valid SHALL be 1.
REQ-017 last SHALL be 1 in the fourth SHIFT cycle, or in the PARITY cycle when the macro is defined.
REQ-018 After the final slot, an accept in that slot SHALL restart SHIFT with no bubble; with no accept, the FSM SHALL return to IDLE.
REQ-019 d SHALL be stable for the whole word; it changes only on accept.
REQ-020 in_valid SHALL be ignored while in_ready=0; in_data is not sampled and no word is lost or duplicated.
REQ-021 In IDLE: y_valid=0, last=0, y=0; s and d hold their last values.
REQ-022 s SHALL wrap 3->0, or 0->3 when LSB_FIRST=0, only through a new accept, never inside a word.

Reset
REQ-023 With rst_n=0 at a rising edge, the outputs SHALL take these values: FSM=IDLE, d=4'b0000, s=2'b00, y=0, y_valid=0, last=0, in_ready=1 on the first cycle after release; in_ready=0 during reset.
REQ-024 Reset mid-word SHALL discard the word; an accept coincident with reset SHALL be discarded.

Configuration
REQ-025 The macro SHALL be MUX_SEL_SEQ_PARITY_EN; when defined, a PARITY slot follows the fourth SHIFT cycle with y = ^d (even parity), y_valid=1, last=1, and s held; throughput is 5 cycles/word.
REQ-026 When MUX_SEL_SEQ_PARITY_EN is undefined, the PARITY state and logic SHALL be absent and throughput is 4 cycles/word.

Structure
REQ-027 A shared package mux_seq_pkg SHALL hold the FSM state enum, SEL_W=2, DATA_W=4 and the slot-count constants.
REQ-028 One sub-module, sel_counter, SHALL implement the 2-bit up/down select counter with load/enable and a terminal flag; everything else is in mux_sel_sequencer.

Verification
REQ-029 Reset then a single word: in_data=4'b1011, LSB_FIRST=1 -> s=0,1,2,3 over 4 cycles, y=1,1,0,1, last on the 4th cycle, then IDLE.
REQ-030 Back-to-back words: 4'b0110 then 4'b1001 held valid -> 8 consecutive y_valid cycles, y=0,1,1,0,1,0,0,1, in_ready pulses only on last.
REQ-031 LSB_FIRST=0 with 4'b0001 -> s=3,2,1,0, y=0,0,0,1.
REQ-032 Reset asserted in the 2nd SHIFT cycle of 4'b1111 -> next cycle y_valid=0, d=0, s=0; no further y of that word.
REQ-033 With MUX_SEL_SEQ_PARITY_EN, 4'b0111 -> y=1,1,1,0, then parity slot y=1, last=1; total 5 cycles.
REQ-034 in_valid toggled while busy with in_data changing -> d unchanged until the last slot; only words offered while in_ready=1 are serialised.
